// File: rtl/mem_line_rmw_if.sv
// Core-side request/response and line-memory side signals of mem_line_rmw.
// The slave modport is the access unit's view; master is the core/memory side.
interface mem_line_rmw_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 4
);
    localparam int unsigned BYTES  = WORD_WIDTH / 8;
    localparam int unsigned LINE_W = WORD_WIDTH * WORDS_PER_LINE;

    logic                  req_read;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic [BYTES-1:0]      req_byte_en;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_W-1:0]     mem_wdata;
    logic [LINE_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_byte_en,
        input  mem_rdata, mem_ready,
        output busy, done, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata, req_byte_en,
        output mem_rdata, mem_ready,
        input  busy, done, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_line_rmw.sv
// Word access unit over a line-organised memory: line fetch + word extract for
// reads, byte-masked read-modify-write of the containing line for writes.
module mem_line_rmw #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input logic           clk,
    input logic           rst_n,
    mem_line_rmw_if.slave bus
);
    localparam int unsigned BYTES    = WORD_WIDTH / 8;
    localparam int unsigned OFF_W    = $clog2(BYTES);
    localparam int unsigned IDX_W    = $clog2(WORDS_PER_LINE);
    localparam int unsigned LINE_OFF = OFF_W + IDX_W;

    typedef logic [BYTES-1:0][7:0]                     word_t;
    typedef logic [WORDS_PER_LINE-1:0][BYTES-1:0][7:0] line_t;
    typedef enum logic [2:0] {IDLE, RD_LINE, MERGE, WR_LINE, RESP} state_t;

    state_t           state_q, state_d;
    line_t            line_q, merged, mem_line;
    word_t            wdata_q;
    logic [BYTES-1:0] be_q;
    logic [IDX_W-1:0] idx_q;
    logic             is_write_q;
    logic             accept;
    logic             unused_addr_bits;

    assign mem_line         = bus.mem_rdata;
    assign accept           = (state_q == IDLE) && (bus.req_write || bus.req_read);
    assign unused_addr_bits = ^bus.req_addr;

    // Next-state logic; write wins over read when both are requested
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_write) begin
                    if (~|bus.req_byte_en)     state_d = RESP;
                    else if (&bus.req_byte_en) state_d = MERGE;
                    else                       state_d = RD_LINE;
                end else if (bus.req_read) begin
                    state_d = RD_LINE;
                end
            end
            RD_LINE: if (bus.mem_ready) state_d = is_write_q ? MERGE : RESP;
            MERGE:   state_d = WR_LINE;
            WR_LINE: if (bus.mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte-lane merge of the latched write word into the buffered line
    always_comb begin
        merged = line_q;
        for (int b = 0; b < int'(BYTES); b++) begin
            if (be_q[b]) merged[idx_q][b] = wdata_q[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Registered outputs are derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            line_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            idx_q         <= '0;
            is_write_q    <= 1'b0;
        end else begin
            bus.busy      <= (state_d != IDLE);
            bus.done      <= (state_d == RESP);
            bus.mem_read  <= (state_d == RD_LINE);
            bus.mem_write <= (state_d == WR_LINE);

            if (accept) begin
                bus.mem_addr <= {bus.req_addr[ADDR_WIDTH-1:LINE_OFF], LINE_OFF'(0)};
                idx_q        <= bus.req_addr[OFF_W +: IDX_W];
                wdata_q      <= bus.req_wdata;
                be_q         <= bus.req_byte_en;
                is_write_q   <= bus.req_write;
            end

            if (state_q == RD_LINE && bus.mem_ready) line_q <= mem_line;

            if (state_q == MERGE) begin
                line_q        <= merged;
                bus.mem_wdata <= merged;
            end

            // Empty writes enter RESP straight from IDLE and report zero
            if (state_d == RESP) begin
                case (state_q)
                    IDLE:    bus.rdata <= '0;
                    RD_LINE: bus.rdata <= mem_line[idx_q];
                    default: bus.rdata <= line_q[idx_q];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_line_rmw.sv
// Self-checking bench for mem_line_rmw: directed vector table, reset abort
// sequence and randomized operations against a word/line-level reference model.
module tb_mem_line_rmw;
    localparam int unsigned AW  = 32;
    localparam int unsigned WW  = 32;
    localparam int unsigned WPL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_line_rmw_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORDS_PER_LINE(WPL)) bus ();

    mem_line_rmw #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORDS_PER_LINE(WPL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        bit          hold;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Memory contents served to the DUT, and the model's view of memory and line buffer
    logic [127:0] ram     [32];
    logic [127:0] ref_mem [32];
    logic [127:0] ref_buf;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int waits,
                          input bit hold, input bit use_tab, input logic [31:0] tab_rdata,
                          input int tab_lat, input string name);
        logic [127:0] line, exp_line;
        logic [31:0]  mask, exp_rd, laddr;
        int li, idx, nr, nw, lat, edges, wcnt, rseen, wseen;
        bit got_done, bad_addr, bad_busy, bad_both, bad_wdata;

        li = int'(addr[8:4]);
        idx = int'(addr[3:2]);
        laddr = {addr[31:4], 4'h0};
        nr = 0; nw = 0; exp_line = '0; exp_rd = '0; mask = '0;
        if (wr) begin
            if (be != 4'h0) begin
                for (int b = 0; b < 4; b++) mask[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
                line = (be == 4'hF) ? ref_buf : ref_mem[li];
                exp_rd = (line[idx*32 +: 32] & ~mask) | (wdata & mask);
                line[idx*32 +: 32] = exp_rd;
                ref_buf = line;
                ref_mem[li] = line;
                exp_line = line;
                nr = (be == 4'hF) ? 0 : 1;
                nw = 1;
            end
        end else begin
            ref_buf = ref_mem[li];
            exp_rd = ref_buf[idx*32 +: 32];
            nr = 1;
        end
        lat = 1 + nr + 2 * nw + waits * (nr + nw);
        if (use_tab) begin
            exp_rd = tab_rdata;
            lat = tab_lat;
        end

        @(negedge clk);
        bus.req_read = rd; bus.req_write = wr; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_byte_en = be;
        @(posedge clk);
        edges = 1; wcnt = 0; rseen = 0; wseen = 0;
        got_done = 0; bad_addr = 0; bad_busy = 0; bad_both = 0; bad_wdata = 0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            @(negedge clk);
            if (hold) begin
                bus.req_addr = ~addr; bus.req_wdata = ~wdata; bus.req_byte_en = ~be;
            end else begin
                bus.req_read = 1'b0; bus.req_write = 1'b0;
            end
            if (!bus.busy) bad_busy = 1;
            if (bus.done) begin
                got_done = 1;
            end else begin
                if (bus.mem_read && bus.mem_write) bad_both = 1;
                if (bus.mem_read || bus.mem_write) begin
                    if (bus.mem_addr !== laddr) bad_addr = 1;
                    if (bus.mem_write && bus.mem_wdata !== exp_line) bad_wdata = 1;
                    if (wcnt < waits) begin
                        wcnt++;
                        bus.mem_ready = 1'b0;
                    end else begin
                        wcnt = 0;
                        bus.mem_ready = 1'b1;
                        if (bus.mem_read) begin
                            bus.mem_rdata = ram[bus.mem_addr[8:4]];
                            rseen++;
                        end else begin
                            ram[bus.mem_addr[8:4]] = bus.mem_wdata;
                            wseen++;
                        end
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                end
                @(posedge clk);
                edges++;
            end
        end
        bus.req_read = 1'b0; bus.req_write = 1'b0; bus.mem_ready = 1'b0;

        check({name, " done_seen"}, 128'(got_done), 128'(1));
        check({name, " latency"}, 128'(edges), 128'(lat));
        check({name, " rdata"}, 128'(bus.rdata), 128'(exp_rd));
        check({name, " line_reads"}, 128'(rseen), 128'(nr));
        check({name, " line_writes"}, 128'(wseen), 128'(nw));
        check({name, " addr/busy/excl/wdata errs"},
              128'({bad_addr, bad_busy, bad_both, bad_wdata}), 128'(0));
        @(posedge clk);
        @(negedge clk);
        check({name, " done_busy_after"}, 128'({bus.done, bus.busy}), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab [6];
        logic [31:0] ra, rw;
        logic [3:0]  rbe;
        int          sel, seen;

        tab[0] = '{1'b1, 1'b0, 32'h108, 32'h0,        4'h0,    0, 1'b0, 32'hCCCCCCCC, 2};
        tab[1] = '{1'b0, 1'b1, 32'h104, 32'h12345678, 4'b0011, 0, 1'b0, 32'hBBBB5678, 4};
        tab[2] = '{1'b0, 1'b1, 32'h10C, 32'hCAFEF00D, 4'hF,    0, 1'b0, 32'hCAFEF00D, 3};
        tab[3] = '{1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0,    0, 1'b0, 32'h0,        1};
        tab[4] = '{1'b1, 1'b1, 32'h104, 32'hA5A5A5A5, 4'b1100, 3, 1'b1, 32'hA5A55678, 10};
        tab[5] = '{1'b1, 1'b0, 32'h10C, 32'h0,        4'h0,    1, 1'b0, 32'hCAFEF00D, 3};

        for (int i = 0; i < 32; i++) begin
            ram[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ref_mem[i] = ram[i];
        end
        ram[16] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        ref_mem[16] = ram[16];
        ref_buf = '0;

        bus.req_read = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_byte_en = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("reset strobes", 128'({bus.busy, bus.done, bus.mem_read, bus.mem_write}), 128'(0));
        check("reset rdata", 128'(bus.rdata), 128'(0));
        check("reset mem_addr", 128'(bus.mem_addr), 128'(0));
        check("reset mem_wdata", bus.mem_wdata, 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(tab[i].rd, tab[i].wr, tab[i].addr, tab[i].wdata, tab[i].be, tab[i].waits,
                   tab[i].hold, 1'b1, tab[i].exp_rdata, tab[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Abort a partial write while it waits in the line-write phase
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_addr = 32'h104;
        bus.req_wdata = 32'h0BADBEEF; bus.req_byte_en = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        bus.req_write = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (bus.mem_write) begin
                seen = 1;
            end else begin
                bus.mem_ready = bus.mem_read;
                bus.mem_rdata = ram[16];
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.mem_ready = 1'b0;
        check("abort reached write phase", 128'(seen), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort async clear", 128'({bus.mem_write, bus.busy, bus.done}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ref_buf = '0;
        run_op(1'b0, 1'b1, 32'h200, 32'h13579BDF, 4'hF, 0, 1'b0, 1'b1, 32'h13579BDF, 3,
               "post-reset full write");
        run_op(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'hA5A55678, 2,
               "post-reset read");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            rw = $urandom();
            sel = $urandom_range(0, 5);
            rbe = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom());
            sel = $urandom_range(0, 2);
            run_op(sel != 1, sel != 0, ra, rw, rbe, $urandom_range(0, 2), 1'b0, 1'b0,
                   32'h0, 0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_line_rmw.md
Name: mem_line_rmw

Overview:
- Parametrised data-memory access unit that sits between the multi-cycle core and a wide line-organised data memory.
- Serves word reads by fetching a line and extracting one word.
- Serves byte-masked word writes by read-modify-write of the containing line, with a handshake on both sides.
- Generalises the fixed 4-word/128-bit word select and merge to any line geometry, and adds byte enables, a full-word fast path and a registered completion pulse.

Parameters:
ADDR_WIDTH, 32, byte-address width
WORD_WIDTH, 32, CPU word width in bits (multiple of 8)
WORDS_PER_LINE, 4, words per memory line (power of 2, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_read  input  1  read request, sampled only in IDLE
req_write  input  1  write request, sampled only in IDLE; wins over req_read if both high
req_addr  input  ADDR_WIDTH  byte address; low log2(WORD_WIDTH/8) bits ignored
req_wdata  input  WORD_WIDTH  write data
req_byte_en  input  WORD_WIDTH/8  byte lanes to write
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
rdata  output  WORD_WIDTH  read word (read) or merged word (write); valid while done=1, held until next done
mem_read  output  1  line read strobe, held until mem_ready
mem_write  output  1  line write strobe, held until mem_ready
mem_addr  output  ADDR_WIDTH  line-aligned address (line-offset bits forced to 0)
mem_wdata  output  WORD_WIDTH*WORDS_PER_LINE  merged line
mem_rdata  input  WORD_WIDTH*WORDS_PER_LINE  line read data, valid when mem_ready=1 during mem_read
mem_ready  input  1  memory completion, sampled only while a strobe is high

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, mem_read and mem_write are 0; rdata, mem_addr, mem_wdata and the line buffer are 0.
- Word index = req_addr[log2(WORD_WIDTH/8) +: log2(WORDS_PER_LINE)].
- Word 0 occupies line bits [WORD_WIDTH-1:0]; word i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- Address, data, byte enables and index are latched on acceptance. Request inputs are ignored while busy.
- States: IDLE, RD_LINE, MERGE, WR_LINE, RESP.
- IDLE transitions:
  - req_write with byte_en all 0: -> RESP. No memory access; rdata = 0.
  - req_write with byte_en all 1: -> MERGE. Fast path, no line read; the other words are taken from the line buffer as last loaded.
  - Any other req_write: -> RD_LINE.
  - req_read: -> RD_LINE.
- RD_LINE: mem_read=1. When mem_ready=1, capture mem_rdata into the line buffer. Then go to RESP for a read, or MERGE for a write.
- MERGE (1 cycle): replace the enabled bytes of the selected word in the line buffer with req_wdata bytes. Other bytes and other words are unchanged. Drive mem_wdata from the result, then go to WR_LINE.
- WR_LINE: mem_write=1, with mem_wdata and mem_addr stable. When mem_ready=1, go to RESP.
- RESP: done=1 for exactly one cycle. rdata = selected word from the line buffer (after merge for writes). Then go to IDLE.
- mem_read and mem_write are never high together. Strobes drop in the cycle after mem_ready is sampled.
- Latency, counted in rising edges from the accept edge to the edge after which done=1, with mem_ready=1 immediately:
  - read: 2
  - partial write: 4
  - full write: 3
  - empty write: 1
- Each memory-side wait cycle adds 1.
- Back-to-back requests: a new request can be accepted in the cycle after RESP (IDLE). A request held high across RESP is accepted again, so the master must deassert on done.
- Reset mid-operation: abort immediately to IDLE and drop strobes. No done is generated for the aborted request.
- Address wrap: mem_addr is a pure mask, with no increment or wrap logic.

Test Plan:
- Read: line at 0x100 = {0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA}. req_read, addr 0x108, mem_ready immediate -> mem_read with mem_addr=0x100 for 1 cycle; done 2 edges after accept; rdata=0xCCCCCCCC.
- Partial write: same line, addr 0x104, wdata 0x12345678, byte_en 4'b0011 -> mem_read, then mem_write with mem_wdata word1=0xBBBB5678 and other words unchanged; done 4 edges after accept; rdata=0xBBBB5678.
- Full-word write: addr 0x10C, byte_en 4'hF, wdata 0xCAFEF00D -> no mem_read; word3=0xCAFEF00D; done 3 edges after accept.
- Empty write: byte_en 0 -> no strobes; done 1 edge after accept; rdata=0.
- Wait states and priority: req_read and req_write both high, mem_ready delayed 3 cycles in each phase -> write path taken; strobes held steady for 3 cycles; busy=1 throughout; done after 10 edges; new request while busy is ignored.
- Reset mid-op: rst_n low during WR_LINE -> mem_write, busy and done go to 0 asynchronously; after release a read completes normally.
